// File: rtl/stupid_rv_pkg.sv
//------------------------------------------------------------------------------
// Module   : stupid_rv_pkg
// Purpose  : Shared constants and types for the stupid_rv RV32I core:
//            opcodes, funct3 encodings, FSM states and ALU operation select.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stupid_rv_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // ALU funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Load/store funct3
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [0:0] {
      S_EXEC    = 1'b0,
      S_LOAD_WB = 1'b1
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/stupid_rv_alu.sv
//------------------------------------------------------------------------------
// Module   : stupid_rv_alu
// Purpose  : Combinational RV32I integer ALU.
// Ports    : a_i, b_i  - operands
//            op_i      - operation select (alu_op_e)
//            result_o  - 32-bit result, arithmetic mod 2^32
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stupid_rv_alu
   import stupid_rv_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_e     op_i,
   output logic [31:0] result_o
);

   always_comb begin
      result_o = a_i + b_i;
      case (op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_SLL:  result_o = a_i << b_i[4:0];
         ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: result_o = {31'b0, a_i < b_i};
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SRL:  result_o = a_i >> b_i[4:0];
         ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
         ALU_OR:   result_o = a_i | b_i;
         ALU_AND:  result_o = a_i & b_i;
         default:  result_o = a_i + b_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/stupid_rv.sv
//------------------------------------------------------------------------------
// Module   : stupid_rv
// Purpose  : Minimal single-issue RV32I core. One instruction per cycle,
//            loads take two cycles (EXEC + LOAD_WB).
// Ports    : clock, reset (sync, active-high), stall (freeze request)
//            imem_addr/imem_data   - registered instruction memory
//            dmem_valid/addr/wstrb/wdata/rdata - registered data memory
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stupid_rv
   import stupid_rv_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        dmem_valid,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata
);

   logic [31:0] pc_q, pc_d;
   state_e      state_q, state_d;
   logic [31:0] rf_q [0:31];
   logic [4:0]  ld_rd_q, ld_rd_d;
   logic [2:0]  ld_f3_q, ld_f3_d;
   logic [1:0]  ld_off_q, ld_off_d;

   // Decode fields
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign opcode = imem_data[6:0];
   assign rd     = imem_data[11:7];
   assign funct3 = imem_data[14:12];
   assign rs1    = imem_data[19:15];
   assign rs2    = imem_data[24:20];
   assign imm_i  = {{20{imem_data[31]}}, imem_data[31:20]};
   assign imm_s  = {{20{imem_data[31]}}, imem_data[31:25], imem_data[11:7]};
   assign imm_b  = {{19{imem_data[31]}}, imem_data[31], imem_data[7],
                    imem_data[30:25], imem_data[11:8], 1'b0};
   assign imm_u  = {imem_data[31:12], 12'b0};
   assign imm_j  = {{11{imem_data[31]}}, imem_data[31], imem_data[19:12],
                    imem_data[20], imem_data[30:21], 1'b0};

   // Register read; x0 is hardwired to zero
   logic [31:0] rs1_val, rs2_val;
   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

   // ALU
   alu_op_e     alu_op;
   logic [31:0] alu_b, alu_res;
   assign alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;

   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         F3_ADD:  alu_op = (opcode == OPC_OP && imem_data[30]) ? ALU_SUB : ALU_ADD;
         F3_SLL:  alu_op = ALU_SLL;
         F3_SLT:  alu_op = ALU_SLT;
         F3_SLTU: alu_op = ALU_SLTU;
         F3_XOR:  alu_op = ALU_XOR;
         F3_SR:   alu_op = imem_data[30] ? ALU_SRA : ALU_SRL;
         F3_OR:   alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   end

   stupid_rv_alu u_alu (
      .a_i      (rs1_val),
      .b_i      (alu_b),
      .op_i     (alu_op),
      .result_o (alu_res)
   );

   // Effective address shared by loads, stores and JALR
   logic [31:0] ls_addr, pc_plus4;
   assign ls_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
   assign pc_plus4 = pc_q + 32'd4;

   // Branch condition
   logic br_taken;
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         F3_BEQ:  br_taken = (rs1_val == rs2_val);
         F3_BNE:  br_taken = (rs1_val != rs2_val);
         F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
         F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         F3_BLTU: br_taken = (rs1_val <  rs2_val);
         F3_BGEU: br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   // Load lane extraction using the offset latched in EXEC
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   always_comb begin
      case (ld_off_q)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (ld_f3_q)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_data = {24'b0, ld_byte};
         F3_HU:   ld_data = {16'b0, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   // Next-state / outputs
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   always_comb begin
      pc_d       = pc_plus4;
      state_d    = state_q;
      ld_rd_d    = ld_rd_q;
      ld_f3_d    = ld_f3_q;
      ld_off_d   = ld_off_q;
      rf_we      = 1'b0;
      rf_waddr   = rd;
      rf_wdata   = alu_res;
      dmem_valid = 1'b0;
      dmem_addr  = ls_addr;
      dmem_wstrb = 4'b0000;
      dmem_wdata = rs2_val;

      case (state_q)
         S_LOAD_WB: begin
            // rdata is only valid this cycle, so stall is ignored here
            pc_d     = pc_q;
            rf_we    = 1'b1;
            rf_waddr = ld_rd_q;
            rf_wdata = ld_data;
            state_d  = S_EXEC;
         end
         default: begin
            if (stall) begin
               pc_d = pc_q;
            end else begin
               case (opcode)
                  OPC_OP, OPC_OP_IMM: rf_we = 1'b1;
                  OPC_LUI: begin
                     rf_we    = 1'b1;
                     rf_wdata = imm_u;
                  end
                  OPC_AUIPC: begin
                     rf_we    = 1'b1;
                     rf_wdata = pc_q + imm_u;
                  end
                  OPC_JAL: begin
                     rf_we    = 1'b1;
                     rf_wdata = pc_plus4;
                     pc_d     = pc_q + imm_j;
                  end
                  OPC_JALR: begin
                     rf_we    = 1'b1;
                     rf_wdata = pc_plus4;
                     pc_d     = {ls_addr[31:1], 1'b0};
                  end
                  OPC_BRANCH: begin
                     if (br_taken) pc_d = pc_q + imm_b;
                  end
                  OPC_LOAD: begin
                     dmem_valid = 1'b1;
                     ld_rd_d    = rd;
                     ld_f3_d    = funct3;
                     ld_off_d   = ls_addr[1:0];
                     state_d    = S_LOAD_WB;
                  end
                  OPC_STORE: begin
                     dmem_valid = 1'b1;
                     case (funct3)
                        F3_B: begin
                           dmem_wstrb = 4'b0001 << ls_addr[1:0];
                           dmem_wdata = {4{rs2_val[7:0]}};
                        end
                        F3_H: begin
                           dmem_wstrb = ls_addr[1] ? 4'b1100 : 4'b0011;
                           dmem_wdata = {2{rs2_val[15:0]}};
                        end
                        default: dmem_wstrb = 4'b1111;
                     endcase
                  end
                  default: ; // FENCE/SYSTEM/unknown: NOP
               endcase
            end
         end
      endcase

      imem_addr = pc_d;
      if (reset) begin
         imem_addr  = RESET_ADDR;
         dmem_valid = 1'b0;
         dmem_wstrb = 4'b0000;
         rf_we      = 1'b0;  // reset mid-load abandons the writeback
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q     <= RESET_ADDR;
         state_q  <= S_EXEC;
         ld_rd_q  <= 5'd0;
         ld_f3_q  <= 3'd0;
         ld_off_q <= 2'd0;
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         ld_rd_q  <= ld_rd_d;
         ld_f3_q  <= ld_f3_d;
         ld_off_q <= ld_off_d;
      end
   end

   // Register file is not reset
   always_ff @(posedge clock) begin
      if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
   end

endmodule

`default_nettype wire

// File: tb/tb_stupid_rv.sv
//------------------------------------------------------------------------------
// Module   : tb_stupid_rv
// Purpose  : Directed self-checking bench for stupid_rv with behavioural
//            registered instruction and data memories.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stupid_rv;
   import stupid_rv_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic [31:0] imem_addr, imem_data;
   logic        dmem_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;

   logic [31:0] imem [0:255];
   logic [31:0] dmem [0:1023];
   logic        clr_dmem = 1'b1;
   logic [31:0] clr_val  = 32'h0;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   stupid_rv #(.RESET_ADDR(32'h0)) dut (
      .clock      (clock),
      .reset      (reset),
      .stall      (stall),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .dmem_valid (dmem_valid),
      .dmem_addr  (dmem_addr),
      .dmem_wstrb (dmem_wstrb),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata)
   );

   // Registered memories
   always @(posedge clock) begin
      imem_data <= imem[imem_addr[9:2]];
      if (clr_dmem) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= clr_val;
      end else if (dmem_valid) begin
         if (dmem_wstrb == 4'b0000)
            dmem_rdata <= dmem[dmem_addr[11:2]];
         else
            for (int b = 0; b < 4; b++)
               if (dmem_wstrb[b]) dmem[dmem_addr[11:2]][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
      end
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Instruction encoders
   function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, int rd, int rs1, int imm);
      return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
   endfunction
   function automatic logic [31:0] enc_s(logic [2:0] f3, int rs2, int rs1, int imm);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3, imm[4:0], OPC_STORE};
   endfunction
   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, int rd, int rs1, int rs2);
      return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], OPC_OP};
   endfunction
   function automatic logic [31:0] enc_b(logic [2:0] f3, int rs1, int rs2, int imm);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], OPC_BRANCH};
   endfunction
   function automatic logic [31:0] enc_j(int rd, int imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OPC_JAL};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
   endtask

   // One reset cycle; checks reset outputs, leaves time just after release
   task automatic do_reset(input logic [31:0] fill);
      reset    = 1'b1;
      stall    = 1'b0;
      clr_dmem = 1'b1;
      clr_val  = fill;
      @(posedge clock);
      @(negedge clock);
      check_value("rst_imem_addr", imem_addr, 32'h0);
      check_value("rst_dmem_valid", {31'b0, dmem_valid}, 32'h0);
      check_value("rst_dmem_wstrb", {28'b0, dmem_wstrb}, 32'h0);
      reset    = 1'b0;
      clr_dmem = 1'b0;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic load_alu_prog();
      clear_imem();
      imem[0]  = enc_i(OPC_OP_IMM, F3_ADD, 1, 0, 5);
      imem[1]  = enc_i(OPC_OP_IMM, F3_ADD, 2, 0, -3);
      imem[2]  = enc_r(7'b0000000, F3_ADD, 3, 1, 2);
      imem[3]  = enc_r(7'b0000000, F3_SLTU, 4, 2, 1);
      imem[4]  = enc_r(7'b0100000, F3_SR, 5, 2, 1);
      imem[5]  = enc_s(F3_W, 3, 0, 32'h200);
      imem[6]  = enc_s(F3_W, 4, 0, 32'h204);
      imem[7]  = enc_s(F3_W, 5, 0, 32'h208);
      imem[8]  = enc_i(OPC_OP_IMM, F3_ADD, 0, 0, 7);
      imem[9]  = enc_s(F3_W, 0, 0, 32'h20C);
      imem[10] = enc_j(0, 0);
   endtask

   task automatic check_alu_results(input string pfx);
      check_value({pfx, "_x3"}, dmem[32'h200 >> 2], 32'h0000_0002);
      check_value({pfx, "_x4"}, dmem[32'h204 >> 2], 32'h0000_0000);
      check_value({pfx, "_x5"}, dmem[32'h208 >> 2], 32'hFFFF_FFFF);
      check_value({pfx, "_x0"}, dmem[32'h20C >> 2], 32'h0000_0000);
   endtask

   initial begin
      // ---------------- ALU chain, unstalled ----------------
      load_alu_prog();
      do_reset(32'hDEAD_BEEF);
      check_value("first_npc", imem_addr, 32'h4);
      repeat (25) next_cycle();
      check_alu_results("alu");

      // ---------------- ALU chain, stalled over the first sw ----------------
      do_reset(32'hDEAD_BEEF);
      repeat (5) next_cycle();          // pc = 20 (sw x3)
      stall = 1'b1;
      #1;
      check_value("stall_addr0", imem_addr, 32'd20);
      check_value("stall_dv0", {31'b0, dmem_valid}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         check_value("stall_addr", imem_addr, 32'd20);
         check_value("stall_dv", {31'b0, dmem_valid}, 32'h0);
      end
      stall = 1'b0;
      #1;
      check_value("unstall_sw_dv", {31'b0, dmem_valid}, 32'h1);
      check_value("unstall_sw_addr", dmem_addr, 32'h200);
      repeat (25) next_cycle();
      check_alu_results("alu_stalled");

      // ---------------- byte/half stores and loads ----------------
      clear_imem();
      imem[0]  = enc_i(OPC_OP_IMM, F3_ADD, 1, 0, 32'h80);
      imem[1]  = enc_s(F3_B, 1, 0, 32'h101);
      imem[2]  = enc_s(F3_H, 1, 0, 32'h102);
      imem[3]  = enc_i(OPC_LOAD, F3_B, 2, 0, 32'h101);
      imem[4]  = enc_i(OPC_LOAD, F3_BU, 3, 0, 32'h101);
      imem[5]  = enc_s(F3_W, 2, 0, 32'h210);
      imem[6]  = enc_s(F3_W, 3, 0, 32'h214);
      imem[7]  = enc_i(OPC_LOAD, F3_H, 6, 0, 32'h102);
      imem[8]  = enc_i(OPC_LOAD, F3_W, 7, 0, 32'h100);
      imem[9]  = enc_s(F3_W, 7, 0, 32'h218);
      imem[10] = enc_s(F3_W, 6, 0, 32'h21C);
      imem[11] = enc_j(0, 0);
      do_reset(32'h0);
      next_cycle();                      // sb
      check_value("sb_dv", {31'b0, dmem_valid}, 32'h1);
      check_value("sb_addr", dmem_addr, 32'h101);
      check_value("sb_wstrb", {28'b0, dmem_wstrb}, 32'h2);
      check_value("sb_wdata", dmem_wdata, 32'h8080_8080);
      next_cycle();                      // sh
      check_value("sh_wstrb", {28'b0, dmem_wstrb}, 32'hC);
      check_value("sh_wdata", dmem_wdata, 32'h0080_0080);
      next_cycle();                      // lb, EXEC
      check_value("lb_dv", {31'b0, dmem_valid}, 32'h1);
      check_value("lb_wstrb", {28'b0, dmem_wstrb}, 32'h0);
      check_value("lb_npc", imem_addr, 32'd16);
      next_cycle();                      // lb, LOAD_WB
      check_value("lbwb_dv", {31'b0, dmem_valid}, 32'h0);
      check_value("lbwb_addr", imem_addr, 32'd16);
      repeat (7) next_cycle();           // lw, EXEC
      check_value("lw_dv", {31'b0, dmem_valid}, 32'h1);
      next_cycle();                      // lw, LOAD_WB with stall
      stall = 1'b1;
      #1;
      check_value("lwwb_stall_dv", {31'b0, dmem_valid}, 32'h0);
      check_value("lwwb_stall_addr", imem_addr, 32'd36);
      next_cycle();
      check_value("post_wb_stall_addr", imem_addr, 32'd36);
      stall = 1'b0;
      repeat (15) next_cycle();
      check_value("lb_val", dmem[32'h210 >> 2], 32'hFFFF_FF80);
      check_value("lbu_val", dmem[32'h214 >> 2], 32'h0000_0080);
      check_value("lw_stalled_val", dmem[32'h218 >> 2], 32'h0080_8000);
      check_value("lh_val", dmem[32'h21C >> 2], 32'h0000_0080);

      // ---------------- control flow ----------------
      clear_imem();
      imem[0] = enc_i(OPC_OP_IMM, F3_ADD, 9, 0, 0);
      imem[1] = enc_b(F3_BEQ, 0, 0, 8);
      imem[2] = enc_i(OPC_OP_IMM, F3_ADD, 9, 0, 32'h55);
      imem[3] = enc_b(F3_BNE, 0, 0, 8);
      imem[4] = enc_j(1, 16);
      imem[5] = enc_s(F3_W, 1, 0, 32'h220);
      imem[6] = enc_s(F3_W, 9, 0, 32'h224);
      imem[7] = enc_j(0, 0);
      imem[8] = enc_i(OPC_JALR, 3'b000, 0, 1, 1);
      do_reset(32'hDEAD_BEEF);
      next_cycle();
      check_value("beq_taken", imem_addr, 32'd12);
      next_cycle();
      check_value("bne_not_taken", imem_addr, 32'd16);
      next_cycle();
      check_value("jal_target", imem_addr, 32'd32);
      next_cycle();
      check_value("jalr_target", imem_addr, 32'd20);
      repeat (15) next_cycle();
      check_value("jal_link", dmem[32'h220 >> 2], 32'd20);
      check_value("skipped_addi", dmem[32'h224 >> 2], 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
